ext_ram_responder: RTL

Byte-wide asynchronous-SRAM-style target that answers the external RAM pins driven by the CPU memory controller (chip select, output enable, write strobe, 19-bit byte address, 8-bit data). Backs the byte bus with an on-chip word-wide memory using byte-lane writes, and models SRAM read access time and minimum write-pulse width. Used in place of the physical RAM on boards without it, and as the bus-level partner in controller simulation.

---
 rtl/ext_ram_responder_pkg.sv | 32 +++
 rtl/ext_ram_responder_byte_lane_ram.sv | 24 ++
 rtl/ext_ram_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ext_ram_responder_pkg.sv
// Shared constants and types for the external RAM responder.
package ext_ram_responder_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Byte-lane select bits for a backing word of dsize bits.
   function automatic int lane_bits(input int dsize);
      return clog2(dsize / 8);
   endfunction

   // Pulse counter width able to hold the value n.
   function automatic int cnt_bits(input int n);
      int b;
      b = clog2(n + 1);
      return (b < 1) ? 1 : b;
   endfunction

   localparam int DSIZE_DEFAULT = 16;
   localparam int L_DEFAULT     = lane_bits(DSIZE_DEFAULT);

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_LOW  = 1'b1
   } wr_state_e;

endpackage

// File: rtl/ext_ram_responder_byte_lane_ram.sv
// Word-wide memory with per-byte-lane write enables and an asynchronous read port.
module byte_lane_ram #(
   parameter int DSIZE = 16,
   parameter int ASIZE = 12
) (
   input  logic                 clock,
   input  logic [DSIZE/8-1:0]   lane_we,
   input  logic [ASIZE-1:0]     waddr,
   input  logic [DSIZE-1:0]     wdata,
   input  logic [ASIZE-1:0]     raddr,
   output logic [DSIZE-1:0]     rdata
);
   localparam int LANES = DSIZE / 8;

   logic [DSIZE-1:0] mem [2**ASIZE];

   always_ff @(posedge clock) begin
      for (int i = 0; i < LANES; i++)
         if (lane_we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ext_ram_responder.sv
// SRAM-style byte-bus target: registered pins, write-pulse FSM, latency-modelled read path.
module ext_ram_responder
   import ext_ram_responder_pkg::*;
#(
   parameter int DSIZE    = 16,
   parameter int ASIZE    = 12,
   parameter int READ_LAT = 2,
   parameter int MIN_WE   = 2
) (
   input  logic        clock,
   input  logic        reset_b,
   input  logic        ram_cs_b,
   input  logic        ram_oe_b,
   input  logic        ram_we_b,
   input  logic [18:0] ram_addr,
   input  logic [7:0]  ram_data_in,
   output logic [7:0]  ram_data_out,
   output logic        ram_data_oe,
   output logic        wr_done,
   output logic        wr_err
);
   localparam int L     = lane_bits(DSIZE);
   localparam int LANES = DSIZE / 8;
   localparam int AW    = ASIZE + L;
   localparam int CW    = cnt_bits(MIN_WE);
   localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_WE);
   localparam logic [1:0]    LAT_LOAD = 2'(READ_LAT - 1);

   logic          cs_q, we_q, cs_qq, we_qq;
   logic [AW-1:0] addr_q, addr_qq;
   logic [7:0]    din_q;

   wr_state_e      state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           capture, commit, short_pulse;
   logic [ASIZE-1:0] wr_word;
   logic [L-1:0]   wr_lane;
   logic [7:0]     wr_byte;

   logic [1:0]       lat, lat_eff, lat_nxt;
   logic             rd_active, rd_restart, bypass;
   logic [ASIZE-1:0] rd_word;
   logic [L-1:0]     rd_lane;
   logic [7:0]       rd_byte;
   logic [LANES-1:0] lane_we;
   logic [DSIZE-1:0] rdata;
   logic             we_rise, cs_rise;

   // Upper address bits alias onto the implemented depth.
   logic unused_addr_hi;
   assign unused_addr_hi = ^ram_addr[18:AW];

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         cs_q    <= 1'b1;
         we_q    <= 1'b1;
         cs_qq   <= 1'b1;
         we_qq   <= 1'b1;
         addr_q  <= '0;
         addr_qq <= '0;
         din_q   <= '0;
      end else begin
         cs_q    <= ram_cs_b;
         we_q    <= ram_we_b;
         addr_q  <= ram_addr[AW-1:0];
         din_q   <= ram_data_in;
         cs_qq   <= cs_q;
         we_qq   <= we_q;
         addr_qq <= addr_q;
      end
   end

   assign we_rise = we_q & ~we_qq;
   assign cs_rise = cs_q & ~cs_qq;

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) state <= WR_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      capture     = 1'b0;
      commit      = 1'b0;
      short_pulse = 1'b0;
      case (state)
         WR_IDLE: begin
            if (!cs_q && !we_q) begin
               state_nxt = WR_LOW;
               cnt_nxt   = CW'(1);
               capture   = 1'b1;
            end
         end
         WR_LOW: begin
            if (we_rise || cs_rise) begin
               state_nxt = WR_IDLE;
               cnt_nxt   = '0;
               if (cnt >= MIN_CNT) commit      = 1'b1;
               else                short_pulse = 1'b1;
            end else begin
               capture = 1'b1;
               if (cnt < MIN_CNT) cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = WR_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         cnt     <= '0;
         wr_word <= '0;
         wr_lane <= '0;
         wr_byte <= '0;
         wr_done <= 1'b0;
         wr_err  <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         wr_done <= commit;
         if (capture) begin
            wr_word <= addr_q[AW-1:L];
            wr_lane <= addr_q[L-1:0];
            wr_byte <= din_q;
         end
         if (short_pulse) wr_err <= 1'b1;
      end
   end

   assign lane_we = commit ? (LANES'(1) << wr_lane) : '0;

   byte_lane_ram #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_ram (
      .clock   (clock),
      .lane_we (lane_we),
      .waddr   (wr_word),
      .wdata   ({LANES{wr_byte}}),
      .raddr   (rd_word),
      .rdata   (rdata)
   );

   assign rd_word    = addr_q[AW-1:L];
   assign rd_lane    = addr_q[L-1:0];
   assign rd_active  = !cs_q && we_q;
   assign rd_restart = (addr_q != addr_qq) || (!cs_q && cs_qq);
   // Counter reload is treated as taking effect on the edge that registered the change.
   assign lat_eff    = rd_restart ? LAT_LOAD : lat;
   assign lat_nxt    = (lat_eff == 2'd0) ? 2'd0 : lat_eff - 2'd1;
   // A commit landing this edge must be seen by a read of the same byte.
   assign bypass     = commit && (wr_word == rd_word) && (wr_lane == rd_lane);
   assign rd_byte    = bypass ? wr_byte : rdata[{rd_lane, 3'b000} +: 8];

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         lat          <= '0;
         ram_data_out <= '0;
         ram_data_oe  <= 1'b0;
      end else begin
         ram_data_oe <= !ram_cs_b && !ram_oe_b && ram_we_b;
         if (rd_active) begin
            lat <= lat_nxt;
            if (lat_nxt == 2'd0) ram_data_out <= rd_byte;
         end
      end
   end

endmodule
